rf_exec_sequencer: RTL and testbench

//  Multi-cycle execute/writeback sequencer that drives the 8x8 register_file. Accepts one 16-bit

---
 rtl/proc_pkg.sv | 47 ++++
 rtl/alu8.sv | 40 ++++
 rtl/rf_exec_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_rf_exec_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the register-file execute sequencer: opcodes, FSM
// encoding, instruction field positions and opcode classification helpers.
package proc_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned OP_W    = 4;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_MSB = 8;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_MOV = 4'd6;
    localparam logic [OP_W-1:0] OP_LDI = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_ERR
    } state_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    function automatic logic is_two_src(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU: result plus zero and carry/borrow for one opcode.
module alu8
    import proc_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        result_o = '0;
        c_o      = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                c_o      = wide[DATA_W];
            end
            // The borrow out of a 9-bit subtract is set exactly when a < b.
            OP_SUB: begin
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                c_o      = wide[DATA_W];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_MOV:  result_o = a_i;
            default: result_o = '0;
        endcase
        z_o = (result_o == '0);
    end

endmodule

// File: rtl/rf_exec_sequencer.sv
// Multi-cycle execute/writeback sequencer: reads operands from the 8x8 register
// file, runs the ALU, writes the result back and waits for the write acknowledge.
module rf_exec_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned WR_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               rf_rd_en1,
    output logic               rf_rd_en2,
    output logic [ADDR_W-1:0]  rf_rd_addr1,
    output logic [ADDR_W-1:0]  rf_rd_addr2,
    input  logic [DATA_W-1:0]  rf_rd_data1,
    input  logic [DATA_W-1:0]  rf_rd_data2,
    output logic               rf_wr_en,
    output logic [ADDR_W-1:0]  rf_wr_addr,
    output logic [DATA_W-1:0]  rf_wr_data,
    input  logic               rf_wr_success,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               flag_z,
    output logic               flag_c
);

    localparam int unsigned CNT_W = $clog2(WR_TIMEOUT + 1);

    state_e              state_q;
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                res_z_q, res_c_q;
    logic                instr_ready_q, busy_q, done_q, error_q, flag_z_q, flag_c_q;
    logic                rd_en1_q, rd_en2_q, wr_en_q;
    logic [ADDR_W-1:0]   rd_addr1_q, rd_addr2_q, wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic [OP_W-1:0]     in_op;
    logic [ADDR_W-1:0]   in_rd, in_rs1, in_rs2;
    logic [DATA_W-1:0]   in_imm;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_z, alu_c;

    assign in_op  = instr[OP_MSB:OP_LSB];
    assign in_rd  = instr[RD_MSB:RD_LSB];
    assign in_rs1 = instr[RS1_MSB:RS1_LSB];
    assign in_rs2 = instr[RS2_MSB:RS2_LSB];
    assign in_imm = instr[IMM_MSB:IMM_LSB];

    alu8 u_alu (
        .op_i     (op_q),
        .a_i      (rf_rd_data1),
        .b_i      (rf_rd_data2),
        .result_o (alu_result),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            res_z_q       <= 1'b0;
            res_c_q       <= 1'b0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
            rd_en1_q      <= 1'b0;
            rd_en2_q      <= 1'b0;
            rd_addr1_q    <= '0;
            rd_addr2_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_en1_q <= 1'b0;
            rd_en2_q <= 1'b0;
            wr_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid && instr_ready_q) begin
                        op_q <= in_op;
                        rd_q <= in_rd;
                        if (in_op == OP_NOP) begin
                            done_q <= 1'b1;
                        end else if (is_alu_op(in_op)) begin
                            state_q       <= ST_READ;
                            busy_q        <= 1'b1;
                            instr_ready_q <= 1'b0;
                            rd_en1_q      <= 1'b1;
                            rd_addr1_q    <= in_rs1;
                            if (is_two_src(in_op)) begin
                                rd_en2_q   <= 1'b1;
                                rd_addr2_q <= in_rs2;
                            end
                        end else if (in_op == OP_LDI) begin
                            state_q       <= ST_WRITE;
                            busy_q        <= 1'b1;
                            instr_ready_q <= 1'b0;
                            wr_en_q       <= 1'b1;
                            wr_addr_q     <= in_rd;
                            wr_data_q     <= in_imm;
                        end else begin
                            state_q       <= ST_ERR;
                            busy_q        <= 1'b1;
                            instr_ready_q <= 1'b0;
                        end
                    end
                end
                ST_READ: state_q <= ST_EXEC;
                // Operand data is valid now; register result and launch the write.
                ST_EXEC: begin
                    state_q   <= ST_WRITE;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= rd_q;
                    wr_data_q <= alu_result;
                    res_z_q   <= alu_z;
                    res_c_q   <= alu_c;
                end
                ST_WRITE: begin
                    state_q <= ST_WAIT_ACK;
                    cnt_q   <= CNT_W'(WR_TIMEOUT);
                end
                ST_WAIT_ACK: begin
                    if (rf_wr_success) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        instr_ready_q <= 1'b1;
                        done_q        <= 1'b1;
                        if (op_q != OP_LDI) begin
                            flag_z_q <= res_z_q;
                            flag_c_q <= res_c_q;
                        end
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        instr_ready_q <= 1'b1;
                        error_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    instr_ready_q <= 1'b1;
                    error_q       <= 1'b1;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    instr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign rf_rd_en1   = rd_en1_q;
    assign rf_rd_en2   = rd_en2_q;
    assign rf_rd_addr1 = rd_addr1_q;
    assign rf_rd_addr2 = rd_addr2_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_wr_data  = wr_data_q;

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench for rf_exec_sequencer with a behavioural register file that
// acknowledges writes after a programmable delay (0 = never).
module tb_rf_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        rf_rd_en1, rf_rd_en2;
    logic [2:0]  rf_rd_addr1, rf_rd_addr2;
    logic [7:0]  rf_rd_data1, rf_rd_data2;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_success;
    logic        busy, done, error, flag_z, flag_c;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [25:0] RST_VEC = 26'h2000000;

    always #5 clk = ~clk;

    rf_exec_sequencer #(.WR_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_wr_success(rf_wr_success),
        .busy(busy), .done(done), .error(error), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Register file model: registered reads, write ack ack_delay cycles later.
    logic [7:0] regs [8];
    int ack_delay = 1;
    int pend = 0;
    always @(posedge clk) begin
        if (rf_rd_en1) rf_rd_data1 <= regs[rf_rd_addr1];
        if (rf_rd_en2) rf_rd_data2 <= regs[rf_rd_addr2];
        if (rf_wr_en) begin
            regs[rf_wr_addr] <= rf_wr_data;
            pend <= ack_delay;
        end else if (pend != 0) begin
            pend <= pend - 1;
        end
    end
    assign rf_wr_success = (pend == 1);

    // Activity monitor, sampled on the falling edge.
    int wr_cnt = 0, rd1_cnt = 0, rd2_cnt = 0, done_cnt = 0;
    logic [2:0] last_wr_addr = '0, last_rd_addr1 = '0, last_rd_addr2 = '0;
    logic [7:0] last_wr_data = '0;
    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            last_wr_addr <= rf_wr_addr;
            last_wr_data <= rf_wr_data;
        end
        if (rf_rd_en1) begin
            rd1_cnt <= rd1_cnt + 1;
            last_rd_addr1 <= rf_rd_addr1;
        end
        if (rf_rd_en2) begin
            rd2_cnt <= rd2_cnt + 1;
            last_rd_addr2 <= rf_rd_addr2;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [25:0] out_vec();
        return {instr_ready, busy, done, error, flag_z, flag_c, rf_rd_en1, rf_rd_en2,
                rf_rd_addr1, rf_rd_addr2, rf_wr_en, rf_wr_addr, rf_wr_data};
    endfunction

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h7, rd, 1'b0, imm};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins);
        int g;
        tick();
        instr = ins;
        instr_valid = 1'b1;
        g = 0;
        while (instr_ready !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [15:0] ins, output int lat);
        send(ins);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tick();
    endtask

    task automatic test_reset();
        int w0;
        repeat (3) tick();
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_init: got %h want %h", out_vec(), RST_VEC);
        end
        rst = 1'b0;
        // Abort in WAIT_ACK with no acknowledge coming.
        ack_delay = 0;
        send(enc_ldi(3'd7, 8'h55));
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_wait_ack: got %h want %h", out_vec(), RST_VEC);
        end
        w0 = wr_cnt;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if ({wr_cnt - w0, 1'b0 + error} !== {32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_after_release: wr_delta %0d err %b want 0 0", wr_cnt - w0, error);
        end
        // Abort during the write pulse: rf_wr_en must drop with rst.
        ack_delay = 1;
        send(enc_r(4'h1, 3'd3, 3'd1, 3'd2));
        repeat (2) tick();
        n_cmp++;
        if (rf_wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_wr: got %b want 1", rf_wr_en);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_write_async: got %h want %h", out_vec(), RST_VEC);
        end
        w0 = wr_cnt;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (wr_cnt !== w0) begin
            n_bad++;
            $display("FAIL reset_no_late_write: got %0d writes want %0d", wr_cnt, w0);
        end
    endtask

    task automatic test_ldi_add();
        int lat, d0;
        ack_delay = 1;
        d0 = done_cnt;
        run(enc_ldi(3'd1, 8'h03), lat);
        n_cmp++;
        if ({lat[7:0], last_wr_addr, last_wr_data} !== {8'd2, 3'd1, 8'h03}) begin
            n_bad++;
            $display("FAIL ldi_r1: lat %0d wr %0d=%h want lat 2 wr 1=03", lat, last_wr_addr, last_wr_data);
        end
        run(enc_r(4'h1, 3'd2, 3'd1, 3'd1), lat);
        n_cmp++;
        if ({lat[7:0], last_wr_addr, last_wr_data} !== {8'd4, 3'd2, 8'h06}) begin
            n_bad++;
            $display("FAIL add_r2: lat %0d wr %0d=%h want lat 4 wr 2=06", lat, last_wr_addr, last_wr_data);
        end
        n_cmp++;
        if ({flag_z, flag_c, done_cnt - d0} !== {2'b00, 32'd2}) begin
            n_bad++;
            $display("FAIL add_flags_done: z%b c%b dones %0d want z0 c0 dones 2", flag_z, flag_c, done_cnt - d0);
        end
    endtask

    task automatic test_carry();
        int lat;
        run(enc_ldi(3'd1, 8'hF0), lat);
        run(enc_ldi(3'd2, 8'h20), lat);
        run(enc_r(4'h1, 3'd3, 3'd1, 3'd2), lat);
        n_cmp++;
        if ({last_wr_addr, last_wr_data, flag_z, flag_c} !== {3'd3, 8'h10, 2'b01}) begin
            n_bad++;
            $display("FAIL add_carry: wr %0d=%h z%b c%b want 3=10 z0 c1", last_wr_addr, last_wr_data, flag_z, flag_c);
        end
        run(enc_ldi(3'd6, 8'h00), lat);
        n_cmp++;
        if ({last_wr_data, flag_z, flag_c} !== {8'h00, 2'b01}) begin
            n_bad++;
            $display("FAIL ldi_keeps_flags: wr %h z%b c%b want 00 z0 c1", last_wr_data, flag_z, flag_c);
        end
        run(enc_r(4'h2, 3'd4, 3'd2, 3'd1), lat);
        n_cmp++;
        if ({last_wr_addr, last_wr_data, flag_z, flag_c} !== {3'd4, 8'h30, 2'b01}) begin
            n_bad++;
            $display("FAIL sub_borrow: wr %0d=%h z%b c%b want 4=30 z0 c1", last_wr_addr, last_wr_data, flag_z, flag_c);
        end
        run(enc_r(4'h2, 3'd7, 3'd1, 3'd2), lat);
        n_cmp++;
        if ({last_wr_addr, last_wr_data, flag_z, flag_c} !== {3'd7, 8'hD0, 2'b00}) begin
            n_bad++;
            $display("FAIL sub_no_borrow: wr %0d=%h z%b c%b want 7=d0 z0 c0", last_wr_addr, last_wr_data, flag_z, flag_c);
        end
    endtask

    task automatic test_zero();
        int lat, r2;
        r2 = rd2_cnt;
        run(enc_r(4'h5, 3'd5, 3'd1, 3'd1), lat);
        n_cmp++;
        if ({last_wr_addr, last_wr_data, flag_z, flag_c} !== {3'd5, 8'h00, 2'b10}) begin
            n_bad++;
            $display("FAIL xor_zero: wr %0d=%h z%b c%b want 5=00 z1 c0", last_wr_addr, last_wr_data, flag_z, flag_c);
        end
        n_cmp++;
        if ({last_rd_addr1, last_rd_addr2, rd2_cnt - r2} !== {3'd1, 3'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL xor_rd_ports: a1 %0d a2 %0d rd2 %0d want 1 1 1", last_rd_addr1, last_rd_addr2, rd2_cnt - r2);
        end
        run(enc_r(4'h6, 3'd6, 3'd3, 3'd5), lat);
        n_cmp++;
        if ({last_wr_addr, last_wr_data, flag_z, flag_c, rd2_cnt - r2} !== {3'd6, 8'h10, 2'b00, 32'd1}) begin
            n_bad++;
            $display("FAIL mov: wr %0d=%h z%b c%b rd2 %0d want 6=10 z0 c0 rd2 1",
                     last_wr_addr, last_wr_data, flag_z, flag_c, rd2_cnt - r2);
        end
    endtask

    task automatic test_timeout();
        int n, d0, lat;
        ack_delay = 0;
        d0 = done_cnt;
        send(enc_ldi(3'd0, 8'h11));
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 9) begin
            n_bad++;
            $display("FAIL timeout_cycles: error after %0d cycles want 9", n);
        end
        n_cmp++;
        if ({done_cnt - d0, busy, instr_ready} !== {32'd0, 2'b01}) begin
            n_bad++;
            $display("FAIL timeout_idle: dones %0d busy %b ready %b want 0 0 1", done_cnt - d0, busy, instr_ready);
        end
        ack_delay = 1;
        run(enc_ldi(3'd0, 8'h22), lat);
        n_cmp++;
        if ({lat[7:0], last_wr_data, error} !== {8'd2, 8'h22, 1'b1}) begin
            n_bad++;
            $display("FAIL error_sticky: lat %0d wr %h err %b want 2 22 1", lat, last_wr_data, error);
        end
    endtask

    task automatic test_back_to_back();
        int r1, d0, w0;
        ack_delay = 1;
        r1 = rd1_cnt;
        d0 = done_cnt;
        tick();
        instr = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b1;
        repeat (15) tick();
        instr_valid = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if ({rd1_cnt - r1, done_cnt - d0} !== {32'd3, 32'd3}) begin
            n_bad++;
            $display("FAIL held_valid: accepts %0d dones %0d want 3 3", rd1_cnt - r1, done_cnt - d0);
        end
        r1 = rd1_cnt;
        w0 = wr_cnt;
        send(16'h0000);
        n_cmp++;
        if ({done, rd1_cnt - r1, wr_cnt - w0} !== {1'b1, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL nop: done %b rd %0d wr %0d want 1 0 0", done, rd1_cnt - r1, wr_cnt - w0);
        end
    endtask

    task automatic test_illegal();
        int r1, r2, w0, d0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL error_cleared: got %b want 0", error);
        end
        r1 = rd1_cnt; r2 = rd2_cnt; w0 = wr_cnt; d0 = done_cnt;
        send(16'hA000);
        repeat (3) tick();
        n_cmp++;
        if ({error, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL illegal_error: err %b busy %b want 1 0", error, busy);
        end
        n_cmp++;
        if ({rd1_cnt - r1, rd2_cnt - r2, wr_cnt - w0, done_cnt - d0} !== 128'd0) begin
            n_bad++;
            $display("FAIL illegal_no_access: rd1 %0d rd2 %0d wr %0d done %0d want 0 0 0 0",
                     rd1_cnt - r1, rd2_cnt - r2, wr_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_carry();
        test_zero();
        test_timeout();
        test_back_to_back();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
